// File: rtl/ooo_control_unit.sv
// Decode/control unit for the 18-bit pipelined core: datapath controls, NZVC flags, branches, hazards.
// Optional MULDIV_EN enables MUL/DIV decode; otherwise op11/op12 decode as NOP.
module ooo_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] instr,
    input  logic        negative,
    input  logic        zero,
    input  logic        overflow,
    input  logic        carry_out,
    input  logic        commandZero,
    output logic [3:0]  flags,
    output logic [3:0]  commandType,
    output logic [4:0]  regRD,
    output logic [2:0]  ALUOp,
    output logic [1:0]  whichMath,
    output logic        ALUSrc,
    output logic        dOrImm,
    output logic        reg2Loc,
    output logic        regWrite,
    output logic        memWrite,
    output logic        read_enable,
    output logic        memToReg,
    output logic        valueToStore,
    output logic        saveCond,
    output logic        leftShift,
    output logic        mult,
    output logic        div,
    output logic        uncondBr,
    output logic        brTaken,
    output logic        BRMI,
    output logic        doingABranch,
    output logic        whichFlags,
    output logic        needToForward
);

    logic [3:0] op;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [1:0] kind;
    logic [1:0] cond;
    logic       unused_imm;

    assign op         = instr[17:14];
    assign rd         = instr[13:9];
    assign rn         = instr[8:4];
    assign kind       = instr[13:12];
    assign cond       = instr[11:10];
    assign unused_imm = ^instr[3:0];

    logic [4:0] prev_rd;
    logic       prev_reg_write;
    logic       prev_save_cond;

    assign commandType = op;
    assign regRD       = rd;
    assign whichFlags  = prev_save_cond;

    // Flags set by the previous instruction are still only live on the ALU
    logic sel_n;
    logic sel_z;
    logic sel_v;
    logic cond_met;

    assign sel_n = whichFlags ? negative : flags[3];
    assign sel_z = whichFlags ? zero     : flags[2];
    assign sel_v = whichFlags ? overflow : flags[1];

    always_comb begin
        cond_met = 1'b0;
        unique case (cond)
            2'b00: cond_met = sel_z;
            2'b01: cond_met = !sel_z;
            2'b10: cond_met = sel_n != sel_v;
            2'b11: cond_met = sel_n == sel_v;
            default: cond_met = 1'b0;
        endcase
    end

    logic reads_rd;
    logic reads_rn;

    always_comb begin
        ALUOp        = 3'b000;
        whichMath    = 2'b00;
        ALUSrc       = 1'b0;
        dOrImm       = 1'b0;
        reg2Loc      = 1'b0;
        regWrite     = 1'b0;
        memWrite     = 1'b0;
        read_enable  = 1'b0;
        memToReg     = 1'b0;
        valueToStore = 1'b0;
        saveCond     = 1'b0;
        leftShift    = 1'b0;
        mult         = 1'b0;
        div          = 1'b0;
        uncondBr     = 1'b0;
        brTaken      = 1'b0;
        BRMI         = 1'b0;
        doingABranch = 1'b0;
        reads_rd     = 1'b0;
        reads_rn     = 1'b0;
        unique case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7: begin
                unique case (op)
                    4'd2:    ALUOp = 3'b011;
                    4'd3:    ALUOp = 3'b100;
                    4'd4:    ALUOp = 3'b101;
                    4'd5:    ALUOp = 3'b110;
                    default: ALUOp = 3'b010;
                endcase
                regWrite = 1'b1;
                reg2Loc  = 1'b1;
                saveCond = op == 4'd7;
                reads_rd = 1'b1;
                reads_rn = 1'b1;
            end
            4'd6: begin
                ALUOp    = 3'b010;
                ALUSrc   = 1'b1;
                regWrite = 1'b1;
                reads_rd = 1'b1;
            end
            4'd8: begin
                ALUOp    = 3'b011;
                saveCond = 1'b1;
                reg2Loc  = 1'b1;
                reads_rd = 1'b1;
                reads_rn = 1'b1;
            end
            4'd9, 4'd10: begin
                whichMath = 2'b01;
                leftShift = op == 4'd9;
                regWrite  = 1'b1;
                reads_rd  = 1'b1;
            end
`ifdef MULDIV_EN
            4'd11, 4'd12: begin
                whichMath = (op == 4'd11) ? 2'b10 : 2'b11;
                mult      = op == 4'd11;
                div       = op == 4'd12;
                regWrite  = 1'b1;
                reg2Loc   = 1'b1;
                reads_rd  = 1'b1;
                reads_rn  = 1'b1;
            end
`endif
            4'd13: begin
                ALUOp       = 3'b010;
                ALUSrc      = 1'b1;
                dOrImm      = 1'b1;
                read_enable = 1'b1;
                memToReg    = 1'b1;
                regWrite    = 1'b1;
                reads_rn    = 1'b1;
            end
            4'd14: begin
                ALUOp        = 3'b010;
                ALUSrc       = 1'b1;
                dOrImm       = 1'b1;
                memWrite     = 1'b1;
                valueToStore = 1'b1;
                reads_rd     = 1'b1;
                reads_rn     = 1'b1;
            end
            4'd15: begin
                doingABranch = 1'b1;
                unique case (kind)
                    2'b00: begin
                        uncondBr = 1'b1;
                        brTaken  = 1'b1;
                    end
                    2'b01: begin
                        brTaken  = commandZero;
                        reads_rn = 1'b1;
                    end
                    2'b10: brTaken = cond_met;
                    2'b11: begin
                        BRMI     = 1'b1;
                        uncondBr = 1'b1;
                        brTaken  = 1'b1;
                        reads_rn = 1'b1;
                    end
                    default: brTaken = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // X31 is the zero register, so a write to it never creates a hazard
    assign needToForward = prev_reg_write && (prev_rd != 5'd31) &&
                           ((reads_rd && (rd == prev_rd)) ||
                            (reads_rn && (rn == prev_rd)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags          <= 4'b0000;
            prev_rd        <= 5'd0;
            prev_reg_write <= 1'b0;
            prev_save_cond <= 1'b0;
        end else begin
            prev_rd        <= rd;
            prev_reg_write <= regWrite;
            prev_save_cond <= saveCond;
            if (prev_save_cond)
                flags <= {negative, zero, overflow, carry_out};
        end
    end

endmodule

// File: tb/tb_ooo_control_unit.sv
// Directed self-checking bench for ooo_control_unit.
module tb_ooo_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] instr;
    logic        negative, zero, overflow, carry_out, commandZero;
    logic [3:0]  flags, commandType;
    logic [4:0]  regRD;
    logic [2:0]  ALUOp;
    logic [1:0]  whichMath;
    logic        ALUSrc, dOrImm, reg2Loc, regWrite, memWrite, read_enable;
    logic        memToReg, valueToStore, saveCond, leftShift, mult, div;
    logic        uncondBr, brTaken, BRMI, doingABranch, whichFlags, needToForward;
    logic [20:0] ctrl;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ooo_control_unit dut (
        .clk(clk), .reset(reset), .instr(instr),
        .negative(negative), .zero(zero), .overflow(overflow),
        .carry_out(carry_out), .commandZero(commandZero),
        .flags(flags), .commandType(commandType), .regRD(regRD),
        .ALUOp(ALUOp), .whichMath(whichMath), .ALUSrc(ALUSrc),
        .dOrImm(dOrImm), .reg2Loc(reg2Loc), .regWrite(regWrite),
        .memWrite(memWrite), .read_enable(read_enable), .memToReg(memToReg),
        .valueToStore(valueToStore), .saveCond(saveCond),
        .leftShift(leftShift), .mult(mult), .div(div),
        .uncondBr(uncondBr), .brTaken(brTaken), .BRMI(BRMI),
        .doingABranch(doingABranch), .whichFlags(whichFlags),
        .needToForward(needToForward)
    );

    assign ctrl = {ALUOp, whichMath, ALUSrc, dOrImm, reg2Loc, regWrite,
                   memWrite, read_enable, memToReg, valueToStore, saveCond,
                   leftShift, mult, div, uncondBr, brTaken, BRMI, doingABranch};

    function automatic logic [17:0] mk(input logic [3:0] o, input logic [4:0] d,
                                       input logic [4:0] n, input logic [3:0] i);
        return {o, d, n, i};
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (flags !== 4'h0) begin failures++; $display("FAIL rst_hold_flags got=%h exp=0", flags); end
        checks++; if (whichFlags !== 1'b0) begin failures++; $display("FAIL rst_hold_wf got=%b exp=0", whichFlags); end
        checks++; if (needToForward !== 1'b0) begin failures++; $display("FAIL rst_hold_ntf got=%b exp=0", needToForward); end
        @(posedge clk); #2;
        reset = 1'b0;
        {negative, zero, overflow, carry_out} = 4'hf;
        instr = mk(4'd7, 5'd3, 5'd3, 4'd0);
        tick;
        #1;
        checks++; if (needToForward !== 1'b1) begin failures++; $display("FAIL adds_ntf got=%b exp=1", needToForward); end
        checks++; if (whichFlags !== 1'b1) begin failures++; $display("FAIL adds_wf got=%b exp=1", whichFlags); end
        tick;
        #1;
        checks++; if (flags !== 4'hf) begin failures++; $display("FAIL flags_set got=%h exp=f", flags); end
        #1 reset = 1'b1;
        #1;
        checks++; if (flags !== 4'h0) begin failures++; $display("FAIL async_flags got=%h exp=0", flags); end
        checks++; if (whichFlags !== 1'b0) begin failures++; $display("FAIL async_wf got=%b exp=0", whichFlags); end
        checks++; if (needToForward !== 1'b0) begin failures++; $display("FAIL async_ntf got=%b exp=0", needToForward); end
        tick;
        #1 reset = 1'b0;
        #1;
        checks++; if (needToForward !== 1'b0) begin failures++; $display("FAIL post_rst_ntf got=%b exp=0", needToForward); end
        checks++; if (flags !== 4'h0) begin failures++; $display("FAIL post_rst_flags got=%h exp=0", flags); end
        {negative, zero, overflow, carry_out} = 4'h0;
    endtask

    task automatic test_forwarding;
        tick; instr = mk(4'd1, 5'd3, 5'd1, 4'd0);
        tick; instr = mk(4'd2, 5'd4, 5'd3, 4'd0); #1;
        checks++; if (needToForward !== 1'b1) begin failures++; $display("FAIL fwd_rn got=%b exp=1", needToForward); end
        checks++; if (ALUOp !== 3'b011) begin failures++; $display("FAIL sub_aluop got=%b exp=011", ALUOp); end
        checks++; if (regWrite !== 1'b1) begin failures++; $display("FAIL sub_rw got=%b exp=1", regWrite); end
        tick; instr = mk(4'd1, 5'd31, 5'd1, 4'd0);
        tick; instr = mk(4'd2, 5'd4, 5'd31, 4'd0); #1;
        checks++; if (needToForward !== 1'b0) begin failures++; $display("FAIL fwd_x31 got=%b exp=0", needToForward); end
        tick; instr = mk(4'd1, 5'd3, 5'd1, 4'd0);
        tick; instr = mk(4'd6, 5'd3, 5'd0, 4'd5); #1;
        checks++; if (needToForward !== 1'b1) begin failures++; $display("FAIL fwd_rd got=%b exp=1", needToForward); end
        checks++; if ({ALUOp, ALUSrc, dOrImm, regWrite} !== 6'b010101) begin
            failures++; $display("FAIL addi_ctrl got=%b exp=010101", {ALUOp, ALUSrc, dOrImm, regWrite}); end
        tick; instr = mk(4'd8, 5'd3, 5'd1, 4'd0); #1;
        checks++; if ({ALUOp, saveCond, regWrite, reg2Loc} !== 6'b011101) begin
            failures++; $display("FAIL cmp_ctrl got=%b exp=011101", {ALUOp, saveCond, regWrite, reg2Loc}); end
        tick; instr = mk(4'd2, 5'd3, 5'd3, 4'd0); #1;
        checks++; if (needToForward !== 1'b0) begin failures++; $display("FAIL fwd_after_cmp got=%b exp=0", needToForward); end
        tick; instr = mk(4'd1, 5'd5, 5'd1, 4'd0);
        tick; instr = mk(4'd15, 5'd5, 5'd5, 4'd0); #1;
        checks++; if (needToForward !== 1'b0) begin failures++; $display("FAIL fwd_b got=%b exp=0", needToForward); end
        checks++; if ({uncondBr, brTaken, BRMI, doingABranch} !== 4'b1101) begin
            failures++; $display("FAIL b_ctrl got=%b exp=1101", {uncondBr, brTaken, BRMI, doingABranch}); end
    endtask

    task automatic test_bcond;
        tick; instr = mk(4'd0, 5'd0, 5'd0, 4'd0);
        tick;
        instr = mk(4'd8, 5'd1, 5'd2, 4'd0);
        {negative, zero, overflow, carry_out} = 4'b1000;
        tick; instr = mk(4'd15, 5'b10100, 5'd0, 4'd0); #1;
        checks++; if (whichFlags !== 1'b1) begin failures++; $display("FAIL bc_live_wf got=%b exp=1", whichFlags); end
        checks++; if (brTaken !== 1'b1) begin failures++; $display("FAIL bc_live_lt got=%b exp=1", brTaken); end
        checks++; if ({doingABranch, uncondBr} !== 2'b10) begin failures++; $display("FAIL bc_live_kind got=%b exp=10", {doingABranch, uncondBr}); end
        tick; instr = mk(4'd0, 5'd0, 5'd0, 4'd0); #1;
        checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL bc_flags got=%b exp=1000", flags); end
        checks++; if (whichFlags !== 1'b0) begin failures++; $display("FAIL bc_stored_wf got=%b exp=0", whichFlags); end
        {negative, zero, overflow, carry_out} = 4'b0100;
        instr = mk(4'd15, 5'b10100, 5'd0, 4'd0); #1;
        checks++; if (brTaken !== 1'b1) begin failures++; $display("FAIL bc_stored_lt got=%b exp=1", brTaken); end
        instr = mk(4'd15, 5'b10110, 5'd0, 4'd0); #1;
        checks++; if (brTaken !== 1'b0) begin failures++; $display("FAIL bc_stored_ge got=%b exp=0", brTaken); end
        instr = mk(4'd15, 5'b10000, 5'd0, 4'd0); #1;
        checks++; if (brTaken !== 1'b0) begin failures++; $display("FAIL bc_stored_eq got=%b exp=0", brTaken); end
        instr = mk(4'd15, 5'b10010, 5'd0, 4'd0); #1;
        checks++; if (brTaken !== 1'b1) begin failures++; $display("FAIL bc_stored_ne got=%b exp=1", brTaken); end
        {negative, zero, overflow, carry_out} = 4'b0000;
    endtask

    task automatic test_cbz_br;
        tick;
        instr = mk(4'd15, 5'b01000, 5'd5, 4'd0);
        commandZero = 1'b0; #1;
        checks++; if ({brTaken, uncondBr, doingABranch} !== 3'b001) begin
            failures++; $display("FAIL cbz_nz got=%b exp=001", {brTaken, uncondBr, doingABranch}); end
        commandZero = 1'b1; #1;
        checks++; if (brTaken !== 1'b1) begin failures++; $display("FAIL cbz_z got=%b exp=1", brTaken); end
        commandZero = 1'b0;
        instr = mk(4'd15, 5'b11000, 5'd7, 4'd0); #1;
        checks++; if ({BRMI, brTaken, uncondBr} !== 3'b111) begin
            failures++; $display("FAIL br_ctrl got=%b exp=111", {BRMI, brTaken, uncondBr}); end
    endtask

    task automatic test_mem;
        tick; instr = mk(4'd13, 5'd2, 5'd5, 4'd4); #1;
        checks++; if ({read_enable, memToReg, ALUSrc, dOrImm, regWrite, ALUOp} !== 8'b11111010) begin
            failures++; $display("FAIL ldur_ctrl got=%b exp=11111010", {read_enable, memToReg, ALUSrc, dOrImm, regWrite, ALUOp}); end
        checks++; if (regRD !== 5'd2) begin failures++; $display("FAIL ldur_rd got=%0d exp=2", regRD); end
        tick; instr = mk(4'd14, 5'd6, 5'd5, 4'd4); #1;
        checks++; if ({memWrite, valueToStore, reg2Loc, regWrite, ALUSrc, dOrImm} !== 6'b110011) begin
            failures++; $display("FAIL stur_ctrl got=%b exp=110011", {memWrite, valueToStore, reg2Loc, regWrite, ALUSrc, dOrImm}); end
    endtask

    task automatic test_alu_ops;
        logic [2:0] exp_alu [0:4];
        exp_alu = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
        for (int i = 0; i < 5; i++) begin
            instr = mk(4'(i + 1), 5'd9, 5'd10, 4'd0); #1;
            checks++; if ({ALUOp, regWrite, reg2Loc, saveCond} !== {exp_alu[i], 3'b110}) begin
                failures++; $display("FAIL alu_op%0d got=%b exp=%b", i + 1, {ALUOp, regWrite, reg2Loc, saveCond}, {exp_alu[i], 3'b110}); end
            checks++; if (commandType !== 4'(i + 1)) begin failures++; $display("FAIL ctype%0d got=%0d exp=%0d", i + 1, commandType, i + 1); end
        end
        instr = mk(4'd7, 5'd9, 5'd10, 4'd0); #1;
        checks++; if ({ALUOp, regWrite, reg2Loc, saveCond} !== 6'b010111) begin
            failures++; $display("FAIL adds_ctrl got=%b exp=010111", {ALUOp, regWrite, reg2Loc, saveCond}); end
        instr = mk(4'd9, 5'd9, 5'd0, 4'd3); #1;
        checks++; if ({whichMath, leftShift, regWrite} !== 4'b0111) begin
            failures++; $display("FAIL lsl_ctrl got=%b exp=0111", {whichMath, leftShift, regWrite}); end
        instr = mk(4'd10, 5'd9, 5'd0, 4'd3); #1;
        checks++; if ({whichMath, leftShift, regWrite} !== 4'b0101) begin
            failures++; $display("FAIL lsr_ctrl got=%b exp=0101", {whichMath, leftShift, regWrite}); end
        commandZero = 1'b1;
        instr = mk(4'd0, 5'd9, 5'd10, 4'd7); #1;
        checks++; if (ctrl !== 21'd0) begin failures++; $display("FAIL nop_ctrl got=%h exp=0", ctrl); end
        commandZero = 1'b0;
    endtask

    task automatic test_muldiv;
        tick; instr = mk(4'd11, 5'd4, 5'd5, 4'd0); #1;
`ifdef MULDIV_EN
        checks++; if ({mult, div, whichMath, regWrite, reg2Loc} !== 6'b101011) begin
            failures++; $display("FAIL mul_ctrl got=%b exp=101011", {mult, div, whichMath, regWrite, reg2Loc}); end
        instr = mk(4'd12, 5'd4, 5'd5, 4'd0); #1;
        checks++; if ({mult, div, whichMath, regWrite, reg2Loc} !== 6'b011111) begin
            failures++; $display("FAIL div_ctrl got=%b exp=011111", {mult, div, whichMath, regWrite, reg2Loc}); end
`else
        checks++; if (ctrl !== 21'd0) begin failures++; $display("FAIL mul_off got=%h exp=0", ctrl); end
        instr = mk(4'd12, 5'd4, 5'd5, 4'd0); #1;
        checks++; if (ctrl !== 21'd0) begin failures++; $display("FAIL div_off got=%h exp=0", ctrl); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        instr = '0;
        {negative, zero, overflow, carry_out} = 4'h0;
        commandZero = 1'b0;
        test_reset;
        test_forwarding;
        test_bcond;
        test_cbz_br;
        test_mem;
        test_alu_ops;
        test_muldiv;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ooo_control_unit.md
Name: ooo_control_unit

Overview:
- Control and decode unit for the team's 18-bit-instruction pipelined processor.
- Pairs with the datapath block: decodes the instruction in the decode stage into datapath control signals.
- Holds the architectural NZVC flag register, resolves branches, and detects back-to-back register hazards so the datapath can forward.

Parameters:
- None. The ISA is fixed.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
instr  in  18  decode-stage instruction, fields {op[17:14], rd[13:9], rn[8:4], imm[3:0]}
negative  in  1  live ALU N flag from execute stage
zero  in  1  live ALU Z flag
overflow  in  1  live ALU V flag
carry_out  in  1  live ALU C flag
commandZero  in  1  datapath indicates register read for CBZ equals 0
flags  out  4  stored flags {N,Z,V,C}
commandType  out  4  equals op
regRD  out  5  destination register, equals rd
ALUOp  out  3  000 pass-B, 010 add, 011 sub, 100 and, 101 or, 110 xor
whichMath  out  2  result source: 00 ALU, 01 shifter, 10 multiplier, 11 divider
ALUSrc  out  1  operand B: 0 register, 1 immediate
dOrImm  out  1  immediate type: 0 arithmetic imm4, 1 memory offset
reg2Loc  out  1  read port 2 address: 1 rn field, 0 rd field
regWrite, memWrite, read_enable, memToReg, valueToStore, saveCond, leftShift, mult, div  out  1 each  datapath enables
uncondBr, brTaken, BRMI, doingABranch  out  1 each  branch control
whichFlags  out  1  branch condition source: 1 live flags, 0 stored flags
needToForward  out  1  current sources include previous instruction's destination

Behaviour:
- All outputs are combinational from instr and state, except flags.
- Unlisted controls are 0.
- op0 NOP: all controls 0.
- op1-5 ADD/SUB/AND/OR/XOR: rd <- rd op rn. ALUOp per table, regWrite=1, reg2Loc=1.
- op6 ADDI: rd <- rd + zero-extended imm. ALUOp=010, ALUSrc=1, dOrImm=0, regWrite=1.
- op7 ADDS: same controls as ADD, plus saveCond=1.
- op8 CMP: rd - rn. ALUOp=011, saveCond=1, regWrite=0, reg2Loc=1.
- op9 LSL: rd <- rd << imm. whichMath=01, leftShift=1, regWrite=1.
- op10 LSR: as LSL with leftShift=0.
- op11 MUL: whichMath=10, mult=1, regWrite=1, reg2Loc=1.
- op12 DIV: whichMath=11, div=1, regWrite=1, reg2Loc=1.
- op13 LDUR: rd <- Mem[rn+imm]. ALUOp=010, ALUSrc=1, dOrImm=1, read_enable=1, memToReg=1, regWrite=1.
- op14 STUR: Mem[rn+imm] <- rd. ALUOp=010, ALUSrc=1, dOrImm=1, memWrite=1, valueToStore=1, reg2Loc=0.
- op15 branch: doingABranch=1. Kind is instr[13:12]:
  - 00 B: uncondBr=1, brTaken=1.
  - 01 CBZ on rn: brTaken=commandZero.
  - 10 B.cond: cond instr[11:10] is 00 EQ(Z), 01 NE(!Z), 10 LT(N!=V), 11 GE(N==V).
  - 11 BR: BRMI=1, uncondBr=1, brTaken=1.
- State registers: prevRd, prevRegWrite, prevSaveCond capture rd, regWrite and saveCond every cycle.
- Flag register: when prevSaveCond=1, flags <- {negative, zero, overflow, carry_out}; otherwise it holds.
- whichFlags = prevSaveCond. B.cond evaluates live flags when whichFlags=1, else stored flags.
- needToForward = prevRegWrite AND prevRd != 31 AND prevRd matches a field the current op reads:
  - rd field: ops 1-12 and 14.
  - rn field: ops 1-5, 7, 8, 11-14, and 15 kinds 01 and 11.
- Register 31 is the zero register and never forwards.
- Reset, asynchronous: flags=0, prevRd=0, prevRegWrite=0, prevSaveCond=0. Hence whichFlags=0 and needToForward=0 while reset is held.
- Deasserting reset mid-instruction leaves no stale hazard state.

Optional Feature:
- Macro MULDIV_EN.
- Defined: op11/op12 decode as specified.
- Undefined: op11/op12 decode as NOP, and mult, div and whichMath[1] are constant 0.

Test Plan:
- Reset with stored flags 1111 -> flags=0000, needToForward=0, whichFlags=0 asynchronously, before any clock edge.
- ADD rd=3,rn=1 (18'h04610) then SUB rd=4,rn=3 -> SUB cycle needToForward=1, ALUOp=011, regWrite=1. Same sequence with rd=31 -> needToForward=0.
- CMP with live N=1,V=0, next B.cond LT -> whichFlags=1, brTaken=1, doingABranch=1. One NOP later, flags=1000, whichFlags=0, B.cond LT still taken.
- CBZ: commandZero=0 -> brTaken=0, uncondBr=0; commandZero=1 -> brTaken=1. BR -> BRMI=1, brTaken=1, uncondBr=1.
- LDUR rd=2,rn=5,imm=4 -> read_enable=1, memToReg=1, ALUSrc=1, dOrImm=1, regRD=2. STUR -> memWrite=1, valueToStore=1, reg2Loc=0, regWrite=0.
- op11 with MULDIV_EN defined -> mult=1, whichMath=10, regWrite=1. Undefined -> all controls 0.
